store_buffer: RTL and testbench

- Small in-order FIFO of pending stores between the MEM-stage store path and the data memory write port.
- Decouples store issue from DM write availability: stores are accepted at up to one per cycle and drained to DM one per cycle whenever `drain_en` is high.
- Tracks address hazards so a load never reads stale DM contents.
- Passes the store's PC through so DM's write trace still prints the originating instruction.

---
 rtl/store_buffer_if.sv | 46 ++++
 rtl/store_buffer.sv | 113 +++++++++++
 tb/tb_store_buffer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Store path, DM write port and load-hazard signals of the store buffer.
// DM access-type encodings are provided here when const.v is not in the build.
`ifndef DM_w
`define DM_w 3'b000
`endif
`ifndef DM_h
`define DM_h 3'b001
`endif
`ifndef DM_b
`define DM_b 3'b010
`endif

interface store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_pc;
  logic [31:0] st_addr;
  logic [31:0] st_wd;
  logic [2:0]  st_type;
  logic        drain_en;
  logic        dm_wr;
  logic [31:0] dm_pc;
  logic [31:0] dm_addr;
  logic [31:0] dm_wd;
  logic [2:0]  dm_type;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_type;
  logic        ld_stall;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;

  modport master (
    output st_valid, st_pc, st_addr, st_wd, st_type, drain_en,
    output ld_valid, ld_addr, ld_type,
    input  st_ready, dm_wr, dm_pc, dm_addr, dm_wd, dm_type,
    input  ld_stall, ld_fwd_valid, ld_fwd_data
  );

  modport slave (
    input  st_valid, st_pc, st_addr, st_wd, st_type, drain_en,
    input  ld_valid, ld_addr, ld_type,
    output st_ready, dm_wr, dm_pc, dm_addr, dm_wd, dm_type,
    output ld_stall, ld_fwd_valid, ld_fwd_data
  );
endinterface

// File: rtl/store_buffer.sv
// In-order store FIFO between MEM stage and the DM write port, with load hazard detection.
// Define STORE_BUF_FWD_EN to forward full-word stores to full-word loads instead of stalling.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic          clk,
  input  logic          reset,
  store_buffer_if.slave bus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  typ;
  } entry_t;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_match;
  logic             w_fwd_hit;
  entry_t           w_head;
  logic             w_unused;

  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.st_valid && !w_full;
  assign w_pop   = !w_empty && bus.drain_en;
  assign w_head  = r_mem[r_head];

  assign bus.st_ready = !w_full;
  assign bus.dm_wr    = w_pop;
  assign bus.dm_pc    = w_head.pc;
  assign bus.dm_addr  = w_head.addr;
  assign bus.dm_wd    = w_head.wd;
  assign bus.dm_type  = w_head.typ;

  // An entry is live when its distance from head is below count; the pushing store is never compared.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] w_off;
      assign w_off        = PTR_W'(gi) - r_head;
      assign w_match[gi]  = ({1'b0, w_off} < r_count) &&
                            (r_mem[gi].addr[11:2] == bus.ld_addr[11:2]);
    end
  endgenerate

`ifdef STORE_BUF_FWD_EN
  logic             w_yng_found;
  logic [PTR_W-1:0] w_yng_idx;
  logic [PTR_W-1:0] w_scan;

  // Walk from tail-1 back toward head; the first hit is the youngest matching store.
  always_comb begin
    w_yng_found = 1'b0;
    w_yng_idx   = '0;
    w_scan      = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      w_scan = r_tail - PTR_W'(k);
      if (!w_yng_found && w_match[w_scan]) begin
        w_yng_found = 1'b1;
        w_yng_idx   = w_scan;
      end
    end
  end

  assign w_fwd_hit        = bus.ld_valid && (bus.ld_type == `DM_w) && w_yng_found &&
                            (r_mem[w_yng_idx].typ == `DM_w);
  assign bus.ld_fwd_valid = w_fwd_hit;
  assign bus.ld_fwd_data  = w_fwd_hit ? r_mem[w_yng_idx].wd : '0;
`else
  assign w_fwd_hit        = 1'b0;
  assign bus.ld_fwd_valid = 1'b0;
  assign bus.ld_fwd_data  = '0;
`endif

  assign bus.ld_stall = bus.ld_valid && (|w_match) && !w_fwd_hit;

  assign w_unused = ^{bus.ld_addr[31:12], bus.ld_addr[1:0], bus.ld_type};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= {bus.st_pc, bus.st_addr, bus.st_wd, bus.st_type};
        r_tail        <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: DM write scoreboard plus a reference model of load hazards.
`ifndef DM_w
`define DM_w 3'b000
`endif
`ifndef DM_h
`define DM_h 3'b001
`endif
`ifndef DM_b
`define DM_b 3'b010
`endif

module tb_store_buffer;
  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  typ;
  } st_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  st_t  q[$];
  logic [31:0] pc_ctr;

  store_buffer_if bus ();

  store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_st(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] typ);
    bus.st_valid = 1'b1;
    bus.st_addr  = addr;
    bus.st_wd    = wd;
    bus.st_type  = typ;
    bus.st_pc    = pc_ctr;
    pc_ctr       = pc_ctr + 32'd4;
    tick();
    bus.st_valid = 1'b0;
  endtask

  task automatic drain_all();
    bus.drain_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    check("drain_timeout", 32'(q.size()), 32'd0);
    bus.drain_en = 1'b0;
  endtask

  // Monitor: inputs are stable from here to the next posedge, so this sees what that edge will do.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
    end else begin
      logic        any;
      logic        yfound;
      logic [2:0]  ytyp;
      logic [31:0] ywd;
      logic        fwd;
      any = 1'b0; yfound = 1'b0; ytyp = '0; ywd = '0; fwd = 1'b0;
      check("count_bound", 32'(dut.r_count <= 3'(DEPTH)), 32'd1);
      check("count", 32'(dut.r_count), 32'(q.size()));
      check("st_ready", 32'(bus.st_ready), 32'(q.size() < DEPTH));
      if (bus.ld_valid) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].addr[11:2] == bus.ld_addr[11:2]) begin
            any = 1'b1;
            if (!yfound) begin
              yfound = 1'b1;
              ytyp   = q[i].typ;
              ywd    = q[i].wd;
            end
          end
        end
`ifdef STORE_BUF_FWD_EN
        fwd = (bus.ld_type == `DM_w) && yfound && (ytyp == `DM_w);
`endif
      end
      check("mdl_ld_stall", 32'(bus.ld_stall), 32'(any && !fwd));
      check("mdl_fwd_valid", 32'(bus.ld_fwd_valid), 32'(fwd));
      check("mdl_fwd_data", bus.ld_fwd_data, fwd ? ywd : 32'd0);
      if (bus.dm_wr) begin
        if (q.size() == 0) begin
          check("dm_unexpected", 32'd1, 32'd0);
        end else begin
          st_t e;
          e = q.pop_front();
          check("sb_dm_addr", bus.dm_addr, e.addr);
          check("sb_dm_wd", bus.dm_wd, e.wd);
          check("sb_dm_pc", bus.dm_pc, e.pc);
          check("sb_dm_type", 32'(bus.dm_type), 32'(e.typ));
        end
      end
      if (bus.st_valid && bus.st_ready) begin
        q.push_back('{pc: bus.st_pc, addr: bus.st_addr, wd: bus.st_wd, typ: bus.st_type});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0; n_fail = 0; pc_ctr = 32'h0000_3000;
    reset = 1'b1;
    bus.st_valid = 1'b0; bus.st_pc = '0; bus.st_addr = '0; bus.st_wd = '0; bus.st_type = '0;
    bus.drain_en = 1'b0; bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_type = '0;
    tick(); tick();
    reset = 1'b0;
    bus.drain_en = 1'b1;
    #1;
    check("rst_st_ready", 32'(bus.st_ready), 32'd1);
    check("rst_dm_wr", 32'(bus.dm_wr), 32'd0);
    check("rst_ld_stall", 32'(bus.ld_stall), 32'd0);
    check("rst_fwd_valid", 32'(bus.ld_fwd_valid), 32'd0);
    check("rst_fwd_data", bus.ld_fwd_data, 32'd0);
    check("rst_dm_addr", bus.dm_addr, 32'd0);
    bus.drain_en = 1'b0;

    // 1: single store, then drain
    bus.st_valid = 1'b1; #1;
    check("t1_ready", 32'(bus.st_ready), 32'd1);
    push_st(32'h10, 32'hDEADBEEF, `DM_w);
    check("t1_count", 32'(dut.r_count), 32'd1);
    check("t1_no_wr", 32'(bus.dm_wr), 32'd0);
    bus.drain_en = 1'b1; #1;
    check("t1_dm_wr", 32'(bus.dm_wr), 32'd1);
    check("t1_dm_addr", bus.dm_addr, 32'h10);
    check("t1_dm_wd", bus.dm_wd, 32'hDEADBEEF);
    tick();
    bus.drain_en = 1'b0;
    check("t1_count0", 32'(dut.r_count), 32'd0);

    // 2: fill, reject fifth, drain in order
    for (int i = 0; i < 4; i++) push_st(32'(i * 4), 32'h100 + 32'(i), `DM_w);
    check("t2_full", 32'(bus.st_ready), 32'd0);
    bus.st_valid = 1'b1; bus.st_addr = 32'h100; #1;
    check("t2_rej_ready", 32'(bus.st_ready), 32'd0);
    tick();
    bus.st_valid = 1'b0;
    check("t2_count4", 32'(dut.r_count), 32'd4);
    bus.drain_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_dm_wr", 32'(bus.dm_wr), 32'd1);
      check("t2_order", bus.dm_addr, 32'(i * 4));
      tick();
    end
    bus.drain_en = 1'b0;
    check("t2_count0", 32'(dut.r_count), 32'd0);

    // 3: full with simultaneous push and pop, then wrap
    for (int i = 0; i < 4; i++) push_st(32'h200 + 32'(i * 4), 32'h200 + 32'(i), `DM_w);
    bus.st_valid = 1'b1; bus.st_addr = 32'h300; bus.st_wd = 32'h3; bus.st_type = `DM_w;
    bus.drain_en = 1'b1; #1;
    check("t3_ready", 32'(bus.st_ready), 32'd0);
    check("t3_dm_wr", 32'(bus.dm_wr), 32'd1);
    tick();
    bus.st_valid = 1'b0; bus.drain_en = 1'b0;
    check("t3_count3", 32'(dut.r_count), 32'd3);
    push_st(32'h300, 32'h33, `DM_w);
    check("t3_count4", 32'(dut.r_count), 32'd4);
    drain_all();
    bus.drain_en = 1'b1;
    for (int i = 0; i < 12; i++) push_st(32'h500 + 32'(i * 4), $urandom, `DM_w);
    drain_all();

    // 4: sub-word store hazard
    push_st(32'h21, 32'hAB, `DM_b);
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h20; bus.ld_type = `DM_w; #1;
    check("t4_stall", 32'(bus.ld_stall), 32'd1);
    bus.ld_addr = 32'h40; #1;
    check("t4_nomatch", 32'(bus.ld_stall), 32'd0);
    bus.ld_addr = 32'h20; bus.drain_en = 1'b1; #1;
    check("t4_stall_pop", 32'(bus.ld_stall), 32'd1);
    tick();
    check("t4_clear", 32'(bus.ld_stall), 32'd0);
    bus.ld_valid = 1'b0; bus.drain_en = 1'b0;

    // 5: forwarding from youngest full-word store
    push_st(32'h30, 32'd1, `DM_w);
    push_st(32'h30, 32'd2, `DM_w);
    bus.ld_valid = 1'b1; bus.ld_addr = 32'h30; bus.ld_type = `DM_w; #1;
`ifdef STORE_BUF_FWD_EN
    check("t5_stall", 32'(bus.ld_stall), 32'd0);
    check("t5_fwd_valid", 32'(bus.ld_fwd_valid), 32'd1);
    check("t5_fwd_data", bus.ld_fwd_data, 32'd2);
`else
    check("t5_stall", 32'(bus.ld_stall), 32'd1);
    check("t5_fwd_valid", 32'(bus.ld_fwd_valid), 32'd0);
    check("t5_fwd_data", bus.ld_fwd_data, 32'd0);
`endif
    bus.ld_type = `DM_h; #1;
    check("t5_lh_stall", 32'(bus.ld_stall), 32'd1);
    bus.ld_valid = 1'b0;
    push_st(32'h31, 32'h77, `DM_b);
    bus.ld_valid = 1'b1; bus.ld_type = `DM_w; #1;
    check("t5_partial_stall", 32'(bus.ld_stall), 32'd1);
    check("t5_partial_fwd", 32'(bus.ld_fwd_valid), 32'd0);
    bus.ld_valid = 1'b0;
    drain_all();

    // random traffic against the model
    for (int i = 0; i < 80; i++) begin
      bus.st_valid = 1'($urandom_range(0, 1));
      bus.st_addr  = 32'h400 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      bus.st_wd    = $urandom;
      bus.st_type  = 3'($urandom_range(0, 2));
      bus.st_pc    = pc_ctr;
      pc_ctr       = pc_ctr + 32'd4;
      bus.drain_en = ($urandom_range(0, 2) != 0);
      bus.ld_valid = 1'($urandom_range(0, 1));
      bus.ld_addr  = 32'h400 + 32'($urandom_range(0, 7)) * 4;
      bus.ld_type  = 3'($urandom_range(0, 2));
      tick();
    end
    bus.st_valid = 1'b0; bus.ld_valid = 1'b0;
    drain_all();

    // 6: reset discards pending stores
    for (int i = 0; i < 3; i++) push_st(32'h600 + 32'(i * 4), 32'h60 + 32'(i), `DM_w);
    reset = 1'b1; bus.drain_en = 1'b1;
    tick();
    reset = 1'b0; #1;
    check("t6_dm_wr", 32'(bus.dm_wr), 32'd0);
    check("t6_count", 32'(dut.r_count), 32'd0);
    check("t6_ready", 32'(bus.st_ready), 32'd1);
    tick(); tick(); tick();
    bus.drain_en = 1'b0;
    check("end_queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
